alu_ctrl_exec: RTL and testbench
================================

ALU_CTRL_EXEC -- requirements
Module: alu_ctrl_exec

Interface
REQ-001 Parameter XLEN, default 32: operand and result width; legal values are 8, 16, 32 and 64.
REQ-002 Parameter ITER_SHIFT, default 1: 1 = shifts iterate one bit per cycle; 0 = shifts complete in a single cycle.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: synchronous active-high reset, sampled on the rising edge of clk.
REQ-005 Port in_valid, input, 1: ALUOp, funct, a and b are valid this cycle.
REQ-006 Port in_ready, output, 1: block can accept a new operation this cycle.
REQ-007 Port alu_op, input, 2: {ALUOp1, ALUOp0}; 00 = load/store, 01 = branch, 10 = R-type, 11 = I-type arithmetic.
REQ-008 Port funct, input, 4: {funct7[5], funct3[2:0]}.
REQ-009 Port a, input, XLEN: operand A (rs1).
REQ-010 Port b, input, XLEN: operand B (rs2 or immediate); the shift amount is b[log2(XLEN)-1:0].
REQ-011 Port out_valid, output, 1: result, zero and operation are valid.
REQ-012 Port out_ready, input, 1: the consumer accepts the result this cycle.
REQ-013 Port result, output, XLEN: operation result.
REQ-014 Port zero, output, 1: high when result is all zeros.
REQ-015 Port operation, output, 4: decoded operation code of the held result.
REQ-016 Port busy, output, 1: high while the block is in state SHIFT.

Function
REQ-017 Operation codes SHALL be: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SLT 0111, SLTU 1000, SRA 1101.
REQ-018 alu_op 00 SHALL decode to ADD and alu_op 01 SHALL decode to SUB, regardless of funct.
REQ-019 alu_op 10 SHALL decode on funct3 as follows:
- 000: ADD, or SUB when f7_5 = 1.
- 001: SLL. 010: SLT. 011: SLTU. 100: XOR.
- 101: SRL, or SRA when f7_5 = 1.
- 110: OR. 111: AND.
REQ-020 alu_op 11 SHALL decode identically to alu_op 10, except that funct3 000 is always ADD (f7_5 ignored).
REQ-021 All arithmetic SHALL wrap modulo 2^XLEN.
- SLT compares signed; SLTU compares unsigned; both produce 1 or 0 zero-extended to XLEN.
- SRA replicates a[XLEN-1].
REQ-022 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-023 An operation SHALL be accepted when in_valid & in_ready; operands and the decoded operation are captured at that edge.
REQ-024 in_ready SHALL be 1 in IDLE, 1 in DONE when out_ready = 1, and 0 otherwise.
REQ-025 A non-shift op, any shift with ITER_SHIFT = 0, and a shift with shamt = 0 SHALL go to DONE with out_valid = 1 on the cycle after acceptance (latency 1).
REQ-026 A shift with ITER_SHIFT = 1 and shamt = n > 0 SHALL run as follows:
- enter SHIFT and shift one bit per cycle for n cycles;
- then enter DONE;
- out_valid rises n+1 cycles after acceptance.
REQ-027 In DONE, result, zero and operation SHALL hold stable until out_valid & out_ready.
REQ-028 In DONE with out_ready = 1:
- if in_valid = 1, the block SHALL accept the new op at that edge and follow REQ-025 or REQ-026, so throughput is 1 op per cycle for single-cycle ops;
- otherwise it SHALL return to IDLE.
REQ-029 In DONE with out_ready = 0, the block SHALL stay in DONE and ignore in_valid.
REQ-030 In SHIFT, in_valid SHALL be ignored and out_valid SHALL be 0.
REQ-031 zero SHALL be derived from the registered result and valid whenever out_valid = 1.
REQ-032 Undefined decodes SHALL NOT exist: every alu_op/funct combination maps to a code in REQ-017.

Reset
REQ-033 While rst = 1 at a clock edge, the block SHALL go to IDLE and drive:
- in_ready = 1 on the following cycle;
- out_valid = 0 and busy = 0;
- result = 0, zero = 1 and operation = 0000.
REQ-034 Reset asserted during SHIFT or DONE SHALL abort the operation; no out_valid pulse follows.
REQ-035 rst SHALL take priority over in_valid and out_ready in the same cycle.

Verification
REQ-036 The bench SHALL cover these directed scenarios (XLEN = 32, ITER_SHIFT = 1, out_ready = 1 unless stated):
- alu_op 10, funct 1000, a = 5, b = 7 -> next cycle out_valid = 1, result = 0xFFFFFFFE, operation = 0110, zero = 0.
- alu_op 10, funct 0101, a = 0x80000000, b = 4 -> busy for 4 cycles, out_valid on cycle 5, result = 0x08000000, operation = 0101.
- Same operands as above with funct 1101 -> result = 0xF8000000, operation = 1101.
- alu_op 10, funct 0010, a = 0xFFFFFFFF, b = 1 -> result = 1.
- Same operands with funct 0011 -> result = 0.
- Three back-to-back ADD ops with in_valid held high -> three consecutive out_valid cycles with correct sums.
- With out_ready = 0 for 3 cycles in DONE -> result stable and in_ready = 0 throughout; on release, the next op is accepted the same cycle.
- rst asserted in the 2nd SHIFT cycle of an SLL by 10 -> next cycle IDLE, out_valid = 0, result = 0, and no later out_valid.

Source files
------------

// File: rtl/alu_ctrl_exec.sv
// alu_ctrl_exec
//   Decodes ALU control ({ALUOp1, ALUOp0} plus {funct7[5], funct3}) and
//   executes the operation on XLEN-bit operands. A valid/ready handshake
//   is used on both sides. When ITER_SHIFT is set, shifts run one bit per
//   cycle. Otherwise every operation completes one cycle after acceptance.
//
// Ports
//   clk        : clock; all state changes on its rising edge
//   rst        : synchronous active-high reset
//   in_valid   : alu_op/funct/a/b are valid
//   in_ready   : block can accept an operation this cycle
//   alu_op     : 00 load/store, 01 branch, 10 R-type, 11 I-type arithmetic
//   funct      : {funct7[5], funct3[2:0]}
//   a, b       : operands; the shift amount is b[$clog2(XLEN)-1:0]
//   out_valid  : result/zero/operation are valid (held until accepted)
//   out_ready  : consumer accepts the result
//   result     : operation result
//   zero       : result is all zeros
//   operation  : decoded 4-bit operation code of the held result
//   busy       : an iterative shift is in progress
module alu_ctrl_exec #(
  parameter int XLEN       = 32,
  parameter int ITER_SHIFT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [3:0]      funct,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic [3:0]      operation,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  logic [XLEN-1:0] res_p1;
  logic [3:0]      op_p1;
  logic [SHW-1:0]  cnt_p1;

  logic [3:0]      dec_op;
  logic [SHW-1:0]  shamt;
  logic            accept;
  logic            iter_shift;

  // alu_op 11 is I-type: funct7[5] is part of the immediate for funct3 000,
  // so it never selects SUB there. It still selects SRA for funct3 101.
  function automatic logic [3:0] decode_op(input logic [1:0] aop,
                                           input logic [3:0] fn);
    logic [3:0] op;
    op = OP_ADD;
    case (aop)
      2'b00: op = OP_ADD;
      2'b01: op = OP_SUB;
      default: begin
        case (fn[2:0])
          3'b000: op = (aop == 2'b10 && fn[3]) ? OP_SUB : OP_ADD;
          3'b001: op = OP_SLL;
          3'b010: op = OP_SLT;
          3'b011: op = OP_SLTU;
          3'b100: op = OP_XOR;
          3'b101: op = fn[3] ? OP_SRA : OP_SRL;
          3'b110: op = OP_OR;
          default: op = OP_AND;
        endcase
      end
    endcase
    return op;
  endfunction

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

  function automatic logic [XLEN-1:0] exec_op(input logic [3:0]      op,
                                              input logic [XLEN-1:0] x,
                                              input logic [XLEN-1:0] y);
    logic signed [XLEN-1:0] xs;
    logic signed [XLEN-1:0] ys;
    logic [SHW-1:0]         sh;
    logic [XLEN-1:0]        r;
    xs = $signed(x);
    ys = $signed(y);
    sh = y[SHW-1:0];
    case (op)
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_ADD:  r = x + y;
      OP_XOR:  r = x ^ y;
      OP_SLL:  r = x << sh;
      OP_SRL:  r = x >> sh;
      OP_SUB:  r = x - y;
      OP_SLT:  r = {{(XLEN-1){1'b0}}, (xs < ys)};
      OP_SLTU: r = {{(XLEN-1){1'b0}}, (x < y)};
      OP_SRA:  r = $unsigned(xs >>> sh);
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [XLEN-1:0] shift_step(input logic [3:0]      op,
                                                 input logic [XLEN-1:0] x);
    logic [XLEN-1:0] r;
    case (op)
      OP_SLL:  r = {x[XLEN-2:0], 1'b0};
      OP_SRL:  r = {1'b0, x[XLEN-1:1]};
      OP_SRA:  r = {x[XLEN-1], x[XLEN-1:1]};
      default: r = x;
    endcase
    return r;
  endfunction

  assign dec_op     = decode_op(alu_op, funct);
  assign shamt      = b[SHW-1:0];
  assign in_ready   = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept     = in_valid && in_ready;
  assign iter_shift = (ITER_SHIFT != 0) && is_shift_op(dec_op) && (shamt != '0);

  // Stage p1: operation capture, iterative shift, held result
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      res_p1 <= '0;
      op_p1  <= OP_AND;
      cnt_p1 <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            op_p1 <= dec_op;
            if (iter_shift) begin
              state  <= SHIFT;
              res_p1 <= a;
              cnt_p1 <= shamt;
            end else begin
              state  <= DONE;
              res_p1 <= exec_op(dec_op, a, b);
            end
          end else if (state == DONE && out_ready) begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          // The last shift step and the move to DONE share an edge, so
          // SHIFT lasts exactly shamt cycles.
          res_p1 <= shift_step(op_p1, res_p1);
          cnt_p1 <= cnt_p1 - SHW'(1);
          if (cnt_p1 == SHW'(1)) begin
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_valid = (state == DONE);
  assign busy      = (state == SHIFT);
  assign result    = res_p1;
  assign operation = op_p1;
  assign zero      = (res_p1 == '0);

endmodule

// File: tb/tb_alu_ctrl_exec.sv
// tb_alu_ctrl_exec
//   Directed bench for alu_ctrl_exec (XLEN = 32, ITER_SHIFT = 1). Stimulus
//   pushes the hand-computed expected result into a scoreboard on
//   acceptance. A monitor pops and compares on every output handshake.
module tb_alu_ctrl_exec;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      alu_op;
  logic [3:0]      funct;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic [3:0]      operation;
  logic            busy;

  typedef struct packed {
    logic [XLEN-1:0] res;
    logic [3:0]      op;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  alu_ctrl_exec #(.XLEN(XLEN), .ITER_SHIFT(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .funct     (funct),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .operation (operation),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [XLEN-1:0] er, input logic [3:0] eo);
    exp_t e;
    e.res = er;
    e.op  = eo;
    sb.push_back(e);
  endtask

  // Monitor: every output handshake must match the oldest pending op.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: result 0x%0h op %b, expected no output", result, operation);
      end else begin
        mon_e = sb.pop_front();
        check("result", result, mon_e.res);
        check("operation", operation, mon_e.op);
        check("zero", zero, (mon_e.res == '0));
      end
    end
  end

  // Call at posedge+#1. Returns at posedge+#1 just after acceptance.
  task automatic issue(input logic [1:0] op, input logic [3:0] fn,
                       input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                       input logic [XLEN-1:0] er, input logic [3:0] eo,
                       input bit push);
    int n;
    n = 0;
    alu_op = op; funct = fn; a = x; b = y; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
    end
    @(posedge clk);
    if (push) push_exp(er, eo);
    #1 in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [3:0] fn,
                        input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                        input logic [XLEN-1:0] er, input logic [3:0] eo,
                        input int lat);
    @(posedge clk);
    #1;
    issue(op, fn, x, y, er, eo, 1'b1);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k < lat) begin
        check("out_valid_early", out_valid, 0);
        check("busy_shift", busy, 1);
      end else begin
        check("out_valid_latency", out_valid, 1);
        check("busy_done", busy, 0);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = 2'b00; funct = 4'b0000; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 1);
    check("rst_operation", operation, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single-cycle decodes and arithmetic
    run_op(2'b10, 4'b1000, 32'd5, 32'd7, 32'hFFFF_FFFE, 4'b0110, 1);
    run_op(2'b10, 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd1, 4'b0111, 1);
    run_op(2'b10, 4'b0011, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'b1000, 1);
    run_op(2'b10, 4'b0010, 32'h8000_0000, 32'd1, 32'd1, 4'b0111, 1);
    run_op(2'b10, 4'b0011, 32'h8000_0000, 32'd1, 32'd0, 4'b1000, 1);
    run_op(2'b00, 4'b1111, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'b0010, 1);
    run_op(2'b01, 4'b0000, 32'd3, 32'd3, 32'd0, 4'b0110, 1);
    run_op(2'b11, 4'b1000, 32'd5, 32'd7, 32'd12, 4'b0010, 1);
    run_op(2'b10, 4'b0111, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 4'b0000, 1);
    run_op(2'b10, 4'b0110, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FFF0, 4'b0001, 1);
    run_op(2'b10, 4'b0100, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 4'b0011, 1);

    // Shifts: latency shamt+1, shamt 0 is single-cycle
    run_op(2'b10, 4'b0101, 32'h8000_0000, 32'd4, 32'h0800_0000, 4'b0101, 5);
    run_op(2'b10, 4'b1101, 32'h8000_0000, 32'd4, 32'hF800_0000, 4'b1101, 5);
    run_op(2'b11, 4'b0001, 32'd1, 32'd3, 32'd8, 4'b0100, 4);
    run_op(2'b10, 4'b0001, 32'h0000_1234, 32'h0000_0020, 32'h0000_1234, 4'b0100, 1);
    run_op(2'b10, 4'b1101, 32'h8000_0000, 32'h0000_003F, 32'hFFFF_FFFF, 4'b1101, 32);
    run_op(2'b11, 4'b1101, 32'h0000_00F0, 32'd4, 32'h0000_000F, 4'b1101, 5);

    // Back-to-back ADDs with in_valid held high
    @(posedge clk);
    #1;
    alu_op = 2'b00; funct = 4'b0000; a = 32'd1; b = 32'd2; in_valid = 1'b1;
    @(negedge clk);
    check("b2b_ready0", in_ready, 1);
    @(posedge clk);
    push_exp(32'd3, 4'b0010);
    #1 a = 32'd100; b = 32'd200;
    @(negedge clk);
    check("b2b_valid1", out_valid, 1);
    check("b2b_ready1", in_ready, 1);
    @(posedge clk);
    push_exp(32'd300, 4'b0010);
    #1 a = 32'h7FFF_FFFF; b = 32'd1;
    @(negedge clk);
    check("b2b_valid2", out_valid, 1);
    check("b2b_ready2", in_ready, 1);
    @(posedge clk);
    push_exp(32'h8000_0000, 4'b0010);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("b2b_valid3", out_valid, 1);
    @(negedge clk);
    check("b2b_valid_end", out_valid, 0);

    // Back-pressure: hold DONE for 3 cycles with a pending op offered
    @(posedge clk);
    #1 out_ready = 1'b0;
    issue(2'b00, 4'b0000, 32'h10, 32'h20, 32'h30, 4'b0010, 1'b1);
    alu_op = 2'b10; funct = 4'b0100; a = 32'h0000_F0F0; b = 32'h0000_0FF0; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stall_out_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_result", result, 32'h30);
      check("stall_operation", operation, 4'b0010);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", in_ready, 1);
    @(posedge clk);
    push_exp(32'h0000_FF00, 4'b0011);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("release_next_valid", out_valid, 1);

    // Reset during the second SHIFT cycle of SLL by 10
    @(posedge clk);
    #1;
    issue(2'b10, 4'b0001, 32'd1, 32'd10, 32'd0, 4'b0000, 1'b0);
    @(negedge clk);
    check("abort_busy1", busy, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("abort_busy2", busy, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_result", result, 0);
    check("abort_zero", zero, 1);
    check("abort_in_ready", in_ready, 1);
    check("abort_operation", operation, 0);
    repeat (20) @(negedge clk);

    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
